// File: rtl/keypad_scanner_if.sv
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad-side and key-event signals of the 4x4 keypad scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic [3:0] keypad_row_in;
    logic [3:0] keypad_col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  keypad_row_in,
        output keypad_col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output keypad_row_in,
        input  keypad_col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module      : keypad_scanner
//  Description : Debounced 4x4 matrix-keypad scanner with calculator key codes.
//                Optional auto-repeat enabled by defining KEYPAD_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_CNT   = 250
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    keypad_scanner_if.master kp
);

    localparam int c_TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SCAN_DIV - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CNT - 1);

    generate
        if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_params
            $error("keypad_scanner: SCAN_DIV must be >= 2, DEBOUNCE_CNT and REPEAT_CNT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_row_meta, r_row_sync;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [1:0]          r_col_idx, w_col_idx_nxt;
    logic [3:0]          r_col_out;
    logic [1:0]          r_row_lat, w_row_lat_nxt;
    logic [c_DEB_W-1:0]  r_deb_cnt, w_deb_cnt_nxt;
    logic [3:0]          r_key_code, w_key_code_nxt;
    logic                r_key_valid, w_key_valid_nxt;
    logic                r_key_held, w_key_held_nxt;

    logic                w_tick;
    logic [3:0]          w_row_low;
    logic                w_one_low;
    logic                w_all_high;
    logic [1:0]          w_row_idx;
    logic                w_same_key;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_REP_W = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CNT - 1);
    logic [c_REP_W-1:0]  r_rep_cnt, w_rep_cnt_nxt;
`endif

    // Row and column indices map to the calculator encoding, [row][col].
    function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_tick     = (r_tick_cnt == c_TICK_LAST);
    assign w_row_low  = ~r_row_sync;
    assign w_one_low  = (w_row_low != 4'h0) && ((w_row_low & (w_row_low - 4'h1)) == 4'h0);
    assign w_all_high = (r_row_sync == 4'hF);
    assign w_same_key = w_one_low && (w_row_idx == r_row_lat);

    always_comb begin
        w_row_idx = 2'd0;
        if (w_row_low[1]) w_row_idx = 2'd1;
        if (w_row_low[2]) w_row_idx = 2'd2;
        if (w_row_low[3]) w_row_idx = 2'd3;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_col_idx_nxt   = r_col_idx;
        w_row_lat_nxt   = r_row_lat;
        w_deb_cnt_nxt   = r_deb_cnt;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_cnt_nxt   = r_rep_cnt;
`endif
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_one_low) begin
                        w_row_lat_nxt = w_row_idx;
                        w_deb_cnt_nxt = '0;
                        w_state_nxt   = ST_DEBOUNCE;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_same_key) begin
                        w_state_nxt   = ST_SCAN;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                        if (r_deb_cnt == c_DEB_LAST) begin
                            w_key_code_nxt  = f_key_map(r_row_lat, r_col_idx);
                            w_key_valid_nxt = 1'b1;
                            w_key_held_nxt  = 1'b1;
                            w_state_nxt     = ST_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                            w_rep_cnt_nxt   = '0;
`endif
                        end
                    end
                end
                ST_PRESSED: begin
                    if (w_all_high) begin
                        w_deb_cnt_nxt = '0;
                        w_state_nxt   = ST_RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (r_rep_cnt == c_REP_LAST) begin
                        w_rep_cnt_nxt   = '0;
                        w_key_valid_nxt = 1'b1;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    if (w_all_high) begin
                        w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                        if (r_deb_cnt == c_DEB_LAST) begin
                            w_key_held_nxt = 1'b0;
                            w_state_nxt    = ST_SCAN;
                        end
                    end else begin
                        // Key bounced back down: resume holding without a new strobe.
                        w_deb_cnt_nxt = '0;
                        w_state_nxt   = ST_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rep_cnt_nxt = '0;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_row_meta  <= 4'hF;
            r_row_sync  <= 4'hF;
            r_tick_cnt  <= '0;
            r_col_idx   <= 2'd0;
            r_col_out   <= 4'b1110;
            r_row_lat   <= 2'd0;
            r_deb_cnt   <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_meta  <= kp.keypad_row_in;
            r_row_sync  <= r_row_meta;
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_col_idx   <= w_col_idx_nxt;
            r_col_out   <= ~(4'b0001 << w_col_idx_nxt);
            r_row_lat   <= w_row_lat_nxt;
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end
`endif

    assign kp.keypad_col_out = r_col_out;
    assign kp.key_code       = r_key_code;
    assign kp.key_valid      = r_key_valid;
    assign kp.key_held       = r_key_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Directed self-checking bench for keypad_scanner with a
//                behavioural 4x4 key matrix driving the row lines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int REPEAT_CNT   = 5;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_EXP_HOLD_STROBES = 5;
`else
    localparam int c_EXP_HOLD_STROBES = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] r_pressed;   // bit row*4+col
    logic [3:0]  w_rows;
    logic [3:0]  codes[$];
    int          n_checks;
    int          n_errors;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_CNT   (REPEAT_CNT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        w_rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (r_pressed[r*4+c] && !kif.keypad_col_out[c]) w_rows[r] = 1'b0;
    end
    assign kif.keypad_row_in = w_rows;

    always @(negedge clk)
        if (kif.key_valid === 1'b1) codes.push_back(kif.key_code);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Returns just after the column has switched to target (bounded wait).
    task automatic wait_col(input logic [3:0] target, input string tag);
        int n = 0;
        while (kif.keypad_col_out === target && n < 64) begin step(1); n++; end
        while (kif.keypad_col_out !== target && n < 64) begin step(1); n++; end
        check_val(tag, kif.keypad_col_out, target);
    endtask

    task automatic wait_release(input string tag);
        int n = 0;
        while (kif.key_held !== 1'b0 && n < 100) begin step(1); n++; end
        check_val(tag, kif.key_held, 1'b0);
    endtask

    initial begin
        int n;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        r_pressed = '0;
        step(3);
        check_val("rst_col",   kif.keypad_col_out, 4'b1110);
        check_val("rst_code",  kif.key_code,  4'h0);
        check_val("rst_valid", kif.key_valid, 1'b0);
        check_val("rst_held",  kif.key_held,  1'b0);

        // Column rotation, one dwell = 4 clocks
        rst_n = 1'b1;
        step(3);  check_val("rot_hold", kif.keypad_col_out, 4'b1110);
        step(1);  check_val("rot_c1",   kif.keypad_col_out, 4'b1101);
        step(4);  check_val("rot_c2",   kif.keypad_col_out, 4'b1011);
        step(4);  check_val("rot_c3",   kif.keypad_col_out, 4'b0111);
        step(4);  check_val("rot_c0",   kif.keypad_col_out, 4'b1110);

        // Key 6 (row1, col2): press tick 4 clocks after the column settles,
        // three more ticks of debounce -> strobe 16 clocks after pressing.
        codes.delete();
        wait_col(4'b1011, "k6_wait");
        r_pressed[1*4+2] = 1'b1;
        step(15); check_val("k6_early", kif.key_valid, 1'b0);
        step(1);  check_val("k6_valid", kif.key_valid, 1'b1);
                  check_val("k6_code",  kif.key_code,  4'h6);
                  check_val("k6_held",  kif.key_held,  1'b1);
        step(1);  check_val("k6_pulse", kif.key_valid, 1'b0);
        r_pressed = '0;
        step(14); check_val("k6_held_still", kif.key_held, 1'b1);
        step(1);  check_val("k6_released",   kif.key_held, 1'b0);
        step(3);  check_val("k6_col_frozen", kif.keypad_col_out, 4'b1011);
        step(1);  check_val("k6_col_resume", kif.keypad_col_out, 4'b0111);
        check_val("k6_strobes", codes.size(), 1);

        // Bounce on key A (row0, col3): 2 ticks low, 1 high, then steady
        codes.delete();
        wait_col(4'b0111, "ka_wait");
        r_pressed[0*4+3] = 1'b1;
        step(8);
        r_pressed = '0;
        step(4);
        check_val("ka_bounce_none", codes.size(), 0);
        check_val("ka_bounce_col",  kif.keypad_col_out, 4'b1110);
        r_pressed[0*4+3] = 1'b1;
        n = 0;
        while (codes.size() == 0 && n < 100) begin step(1); n++; end
        check_val("ka_steady_cnt", codes.size(), 1);
        check_val("ka_code", kif.key_code, 4'hA);
        check_val("ka_held", kif.key_held, 1'b1);
        r_pressed = '0;
        wait_release("ka_release");
        check_val("ka_total", codes.size(), 1);

        // Rows 0 and 2 low together on col0: ignored, scanning continues
        codes.delete();
        r_pressed[0*4+0] = 1'b1;
        r_pressed[2*4+0] = 1'b1;
        wait_col(4'b1110, "dbl_wait");
        step(4);  check_val("dbl_advance", kif.keypad_col_out, 4'b1101);
        step(16);
        check_val("dbl_none", codes.size(), 0);
        check_val("dbl_held", kif.key_held, 1'b0);
        r_pressed = '0;

        // Reset in DEBOUNCE of key E (row3, col2)
        codes.delete();
        wait_col(4'b1011, "ke_wait");
        r_pressed[3*4+2] = 1'b1;
        step(6);
        rst_n = 1'b0;
        #1;
        check_val("ke_rst_col",   kif.keypad_col_out, 4'b1110);
        check_val("ke_rst_code",  kif.key_code,  4'h0);
        check_val("ke_rst_valid", kif.key_valid, 1'b0);
        check_val("ke_rst_held",  kif.key_held,  1'b0);
        step(3);
        r_pressed = '0;
        rst_n = 1'b1;
        step(40);
        check_val("ke_no_strobe", codes.size(), 0);

        // Hold key 0 (row3, col0) for 20 ticks past the accept
        codes.delete();
        wait_col(4'b1110, "k0_wait");
        r_pressed[3*4+0] = 1'b1;
        step(16); check_val("k0_first", codes.size(), 1);
        step(80); check_val("k0_strobes", codes.size(), c_EXP_HOLD_STROBES);
        r_pressed = '0;
        wait_release("k0_release");
        check_val("k0_total", codes.size(), c_EXP_HOLD_STROBES);
        for (int i = 0; i < codes.size(); i++) check_val("k0_code", codes[i], 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
